// File: rtl/cache_pkg.sv
// Shared types and address-geometry helpers for the instruction cache.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Word-offset bits inside a line (0 when a line is a single word).
    function automatic int off_bits(input int block_words);
        return $clog2(block_words);
    endfunction

    // Set-index bits.
    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits: whatever is left of a 32-bit byte address above byte/offset/index.
    function automatic int tag_bits(input int sets, input int block_words);
        return 30 - idx_bits(sets) - off_bits(block_words);
    endfunction

    // Word-counter width; kept at least one bit so single-word lines still elaborate.
    function automatic int cnt_bits(input int block_words);
        return (block_words > 1) ? $clog2(block_words) : 1;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid/tag/data arrays, combinational lookup, single-word fill port.
module icache_way #(
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 2,
    parameter int IDX_W       = 3,
    parameter int CNT_W       = 1,
    parameter int TAG_W       = 26
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    input  logic [CNT_W-1:0] rd_off_i,
    output logic             hit_o,
    output logic             vld_o,
    output logic [31:0]      word_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [CNT_W-1:0] wr_off_i,
    input  logic [31:0]      wr_data_i,
    input  logic             set_en_i,
    input  logic [TAG_W-1:0] set_tag_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][BLOCK_WORDS];

    assign vld_o  = valid_q[rd_idx_i];
    assign hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign word_o = data_q[rd_idx_i][rd_off_i];

    // Valid bits: cleared by reset or flush, set only when a whole line has landed.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) valid_q <= '0;
        else if (set_en_i)  valid_q[wr_idx_i] <= 1'b1;
    end

    // Tag and data storage need no reset; valid gates every use.
    always_ff @(posedge clk_i) begin
        if (set_en_i) tag_q[wr_idx_i] <= set_tag_i;
        if (wr_en_i)  data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end

endmodule

// File: rtl/icache_nway.sv
// N-way (1 or 2) set-associative instruction cache with LRU, flush and miss counter.
module icache_nway
    import cache_pkg::*;
#(
    parameter int CPUID       = 0,
    parameter int WAYS        = 2,
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [15:0] miss_count
);

    localparam int OFF_W = off_bits(BLOCK_WORDS);
    localparam int IDX_W = idx_bits(SETS);
    localparam int TAG_W = tag_bits(SETS, BLOCK_WORDS);
    localparam int CNT_W = cnt_bits(BLOCK_WORDS);

    icache_state_t       state_q, state_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
    logic                victim_q, victim_d;
    logic [15:0]         miss_q, miss_d;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [CNT_W-1:0]    req_off;
    logic [WAYS-1:0]     way_hit, way_vld;
    logic [WAYS-1:0][31:0] way_word;
    logic                hit_any, hit_way, victim_pick, last_word;
    logic [31:0]         hit_word;
    logic                wr_en, set_en, lru_upd, lru_val;
    logic [IDX_W-1:0]    lru_idx;

    // The core index only matters to the controller; byte offset is ignored for word fetches.
    logic unused_ok;
    assign unused_ok = ^{imemaddr[1:0], 32'(CPUID)};

    assign req_tag = imemaddr[31 -: TAG_W];
    assign req_idx = imemaddr[2+OFF_W +: IDX_W];
    if (OFF_W > 0) begin : g_off
        assign req_off = imemaddr[2 +: CNT_W];
    end else begin : g_no_off
        assign req_off = '0;
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS(SETS), .BLOCK_WORDS(BLOCK_WORDS),
            .IDX_W(IDX_W), .CNT_W(CNT_W), .TAG_W(TAG_W)
        ) u_way (
            .clk_i    (CLK),
            .rst_i    (RST),
            .clr_i    (flush),
            .rd_idx_i (req_idx),
            .rd_tag_i (req_tag),
            .rd_off_i (req_off),
            .hit_o    (way_hit[w]),
            .vld_o    (way_vld[w]),
            .word_o   (way_word[w]),
            .wr_en_i  (wr_en && (int'(victim_q) == w)),
            .wr_idx_i (fill_idx_q),
            .wr_off_i (word_cnt_q),
            .wr_data_i(iload),
            .set_en_i (set_en && (int'(victim_q) == w)),
            .set_tag_i(fill_tag_q)
        );
    end

    assign hit_any = |way_hit;

    // Select the hitting way's word; tags are unique per set so at most one way hits.
    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++)
            if (way_hit[w]) hit_word = way_word[w];
    end

    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] lru_q;
        assign hit_way     = way_hit[1] & ~way_hit[0];
        assign victim_pick = !way_vld[0] ? 1'b0 : (!way_vld[1] ? 1'b1 : lru_q[req_idx]);
        // lru_q[set] names the way to evict next in that set.
        always_ff @(posedge CLK) begin
            if (RST || flush) lru_q <= '0;
            else if (lru_upd) lru_q[lru_idx] <= lru_val;
        end
    end else begin : g_nolru
        logic unused_lru;
        assign hit_way     = 1'b0;
        assign victim_pick = 1'b0;
        assign unused_lru  = ^{lru_upd, lru_val, lru_idx, way_vld};
    end

    assign last_word  = (word_cnt_q == CNT_W'(BLOCK_WORDS - 1));
    assign imemload   = (state_q == IDLE && hit_any) ? hit_word : '0;
    assign miss_count = miss_q;

    // Next-state and handshake outputs; flush overrides whatever the FSM wanted.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        victim_d   = victim_q;
        miss_d     = miss_q;
        ihit       = 1'b0;
        iREN       = 1'b0;
        iaddr      = '0;
        wr_en      = 1'b0;
        set_en     = 1'b0;
        lru_upd    = 1'b0;
        lru_idx    = req_idx;
        lru_val    = ~hit_way;
        case (state_q)
            IDLE: begin
                ihit = imemREN & hit_any;
                if (imemREN) begin
                    if (hit_any) begin
                        lru_upd = 1'b1;
                    end else begin
                        fill_tag_d = req_tag;
                        fill_idx_d = req_idx;
                        victim_d   = victim_pick;
                        word_cnt_d = '0;
                        miss_d     = miss_q + 16'd1;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = {fill_tag_q, fill_idx_q, {(OFF_W+2){1'b0}}} | (32'(word_cnt_q) << 2);
                if (!iwait) begin
                    wr_en      = 1'b1;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (last_word) begin
                        set_en     = 1'b1;
                        lru_upd    = 1'b1;
                        lru_idx    = fill_idx_q;
                        lru_val    = ~victim_q;
                        word_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d    = IDLE;
            word_cnt_d = '0;
        end
    end

    // Control registers; miss counter survives flush but not reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            victim_q   <= 1'b0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            victim_q   <= victim_d;
            miss_q     <= miss_d;
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench: table vectors, corner-case sequences, random traffic vs a recency-list model.
module tb_icache_nway;

    localparam int SETS = 8;
    localparam int BW   = 2;
    localparam int WAYS = 2;
    localparam int OFFB = $clog2(BW) + 2;

    logic        CLK = 1'b0;
    logic        RST, flush;
    logic        imemREN, ihit, iREN;
    logic        iwait = 1'b1;
    logic [31:0] imemaddr, imemload, iaddr, iload;
    logic [15:0] miss_count;
    logic        imemREN1, ihit1, iREN1, iwait1;
    logic [31:0] imemaddr1, imemload1, iaddr1, iload1;
    logic [15:0] miss_count1;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign iload  = memf(iaddr);
    assign iload1 = memf(iaddr1);

    icache_nway #(.CPUID(0), .WAYS(2), .SETS(SETS), .BLOCK_WORDS(BW)) u_dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
        .imemload(imemload), .flush(flush), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
        .iload(iload), .miss_count(miss_count));

    icache_nway #(.CPUID(1), .WAYS(1), .SETS(SETS), .BLOCK_WORDS(BW)) u_dut1 (
        .CLK(CLK), .RST(RST), .imemREN(imemREN1), .imemaddr(imemaddr1), .ihit(ihit1),
        .imemload(imemload1), .flush(flush), .iREN(iREN1), .iaddr(iaddr1), .iwait(iwait1),
        .iload(iload1), .miss_count(miss_count1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Controller model: stall stall_tgt cycles per word, then accept.
    int stall_cnt = 0;
    int stall_tgt = 2;
    bit rnd_wait  = 0;
    always @(negedge CLK) begin
        if (iREN === 1'b1) begin
            if (stall_cnt < stall_tgt) begin
                iwait = 1'b1;
                stall_cnt++;
            end else begin
                iwait = 1'b0;
                stall_cnt = 0;
                stall_tgt = rnd_wait ? int'($urandom_range(0, 2)) : 2;
            end
        end else begin
            iwait = 1'b1;
            stall_cnt = 0;
        end
    end

    // Reference: per set, resident tags ordered most- to least-recently used.
    int unsigned mtag [SETS][WAYS];
    int          mcnt [SETS];
    int          mc_m = 0;

    function automatic int mset(input logic [31:0] a);
        return int'((a >> OFFB) % SETS);
    endfunction
    function automatic int unsigned mtagof(input logic [31:0] a);
        return a >> (OFFB + $clog2(SETS));
    endfunction
    function automatic int mfind(input int s, input int unsigned t);
        for (int i = 0; i < mcnt[s]; i++) if (mtag[s][i] == t) return i;
        return -1;
    endfunction
    task automatic mrecord(input logic [31:0] a);
        int s = mset(a);
        int unsigned t = mtagof(a);
        int i = mfind(s, t);
        int n;
        if (i < 0) begin
            n = (mcnt[s] < WAYS) ? mcnt[s] + 1 : WAYS;
            i = n - 1;
            mcnt[s] = n;
        end
        for (int j = i; j > 0; j--) mtag[s][j] = mtag[s][j-1];
        mtag[s][0] = t;
    endtask
    task automatic mclear();
        for (int s = 0; s < SETS; s++) mcnt[s] = 0;
    endtask
    function automatic bit mhit(input logic [31:0] a);
        return mfind(mset(a), mtagof(a)) >= 0;
    endfunction

    // Entered just after a FILL-starting edge is pending; returns at negedge+1 once back in IDLE.
    task automatic fill_track(input logic [31:0] base, input bit sw, input logic [31:0] sw_addr,
                              output int words);
        int cyc = 0;
        words = 0;
        @(posedge CLK);
        while (cyc < 200) begin
            @(negedge CLK); #1;
            cyc++;
            if (!iREN) break;
            chk("fill_ihit", 32'(ihit), 32'd0);
            if (!iwait) begin
                chk("fill_iaddr", iaddr, base + 32'(words * 4));
                words++;
                if (sw && words == 1) imemaddr = sw_addr;
            end
        end
        chk("fill_timeout", 32'(cyc < 200), 32'd1);
    endtask

    // One fetch at negedge+1; on a miss follows the fill and checks the hit that follows.
    task automatic access(input logic [31:0] a, input logic eh, input logic [15:0] emc, input string nm);
        int w;
        imemREN = 1'b1;
        imemaddr = a;
        #1;
        chk({nm, "_ihit"}, 32'(ihit), 32'(eh));
        if (eh) begin
            chk({nm, "_data"}, imemload, memf(a));
            chk({nm, "_noiren"}, 32'(iREN), 32'd0);
        end else begin
            mc_m++;
            fill_track(a & ~32'(BW * 4 - 1), 1'b0, 32'd0, w);
            chk({nm, "_words"}, 32'(w), 32'(BW));
            chk({nm, "_after_ihit"}, 32'(ihit), 32'd1);
            chk({nm, "_after_data"}, imemload, memf(a));
        end
        chk({nm, "_mc"}, 32'(miss_count), 32'(emc));
        mrecord(a);
        @(negedge CLK); #1;
    endtask

    task automatic do_flush();
        imemREN = 1'b0;
        flush = 1'b1;
        @(negedge CLK); #1;
        flush = 1'b0;
        mclear();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        exp_hit;
        logic [15:0] exp_mc;
    } vec_t;
    vec_t vecs [10];

    initial begin
        int w, cyc;
        bit seen;
        logic [31:0] a;
        vecs[0] = '{32'h40, 1'b0, 16'd1};
        vecs[1] = '{32'h44, 1'b1, 16'd1};
        vecs[2] = '{32'h80, 1'b0, 16'd2};
        vecs[3] = '{32'h40, 1'b1, 16'd2};
        vecs[4] = '{32'hC0, 1'b0, 16'd3};
        vecs[5] = '{32'h40, 1'b1, 16'd3};
        vecs[6] = '{32'hC0, 1'b1, 16'd3};
        vecs[7] = '{32'h80, 1'b0, 16'd4};
        vecs[8] = '{32'h48, 1'b0, 16'd5};
        vecs[9] = '{32'h4C, 1'b1, 16'd5};

        RST = 1'b1; flush = 1'b0; imemREN = 1'b0; imemaddr = '0;
        imemREN1 = 1'b0; imemaddr1 = '0; iwait1 = 1'b0;
        mclear();
        @(negedge CLK); @(negedge CLK); #1;
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_iren", 32'(iREN), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_load", imemload, 32'd0);
        chk("rst_mc", 32'(miss_count), 32'd0);
        chk("rst_mc1", 32'(miss_count1), 32'd0);
        RST = 1'b0;
        @(negedge CLK); #1;

        // Cold miss, spatial hit, LRU eviction within set 0.
        for (int i = 0; i < 10; i++) access(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_mc, $sformatf("vec%0d", i));

        // Address moves after first fill word: original fill finishes, then the new miss.
        do_flush();
        imemREN = 1'b1; imemaddr = 32'h40; #1;
        chk("sw_ihit", 32'(ihit), 32'd0);
        mc_m++;
        fill_track(32'h40, 1'b1, 32'h100, w);
        chk("sw_words_a", 32'(w), 32'(BW));
        chk("sw_second_miss", 32'(ihit), 32'd0);
        mrecord(32'h40);
        mc_m++;
        fill_track(32'h100, 1'b0, 32'd0, w);
        chk("sw_words_b", 32'(w), 32'(BW));
        chk("sw_hit_b", 32'(ihit), 32'd1);
        chk("sw_data_b", imemload, memf(32'h100));
        chk("sw_mc", 32'(miss_count), 32'(mc_m));
        mrecord(32'h100);
        @(negedge CLK); #1;
        access(32'h40, 1'b1, 16'(mc_m), "sw_a");
        access(32'h100, 1'b1, 16'(mc_m), "sw_b");

        // Flush during the second fill word abandons the fill.
        do_flush();
        imemREN = 1'b1; imemaddr = 32'h40; #1;
        mc_m++;
        @(posedge CLK);
        cyc = 0;
        while (cyc < 20) begin
            @(negedge CLK); #1;
            cyc++;
            if (iREN && !iwait) break;
        end
        chk("fl_first_word", 32'(cyc < 20), 32'd1);
        @(negedge CLK); #1;
        chk("fl_pre_iren", 32'(iREN), 32'd1);
        flush = 1'b1; imemREN = 1'b0;
        @(negedge CLK); #1;
        flush = 1'b0;
        mclear();
        chk("fl_iren", 32'(iREN), 32'd0);
        chk("fl_ihit", 32'(ihit), 32'd0);
        chk("fl_mc", 32'(miss_count), 32'(mc_m));
        access(32'h40, 1'b0, 16'(mc_m + 1), "fl_refill");

        // Flush coinciding with a hit: hit this cycle, gone next.
        imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b1; #1;
        chk("fh_ihit", 32'(ihit), 32'd1);
        chk("fh_data", imemload, memf(32'h40));
        @(negedge CLK); #1;
        flush = 1'b0;
        mclear();
        #1;
        chk("fh_gone", 32'(ihit), 32'd0);
        access(32'h40, 1'b0, 16'(mc_m + 1), "fh_refill");

        // Reset in the middle of a fill.
        imemREN = 1'b1; imemaddr = 32'h80; #1;
        @(posedge CLK);
        @(negedge CLK); #1;
        chk("rm_pre_iren", 32'(iREN), 32'd1);
        RST = 1'b1; imemREN = 1'b0;
        @(negedge CLK); #1;
        RST = 1'b0;
        chk("rm_ihit", 32'(ihit), 32'd0);
        chk("rm_iren", 32'(iREN), 32'd0);
        chk("rm_iaddr", iaddr, 32'd0);
        chk("rm_load", imemload, 32'd0);
        chk("rm_mc", 32'(miss_count), 32'd0);
        mc_m = 0;
        mclear();
        access(32'h40, 1'b0, 16'd1, "rm_refill");

        // Random traffic over 8 tags x 8 sets with random controller stalls.
        rnd_wait = 1;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush();
            end else begin
                a = 32'($urandom_range(0, 127)) << 2;
                if (mhit(a)) access(a, 1'b1, 16'(mc_m), "rnd");
                else         access(a, 1'b0, 16'(mc_m + 1), "rnd");
            end
        end
        rnd_wait = 0;
        imemREN = 1'b0;

        // Direct-mapped build: two lines in the same set keep evicting each other.
        @(negedge CLK); #1;
        for (int k = 0; k < 6; k++) begin
            a = (k % 2 == 0) ? 32'h40 : 32'h80;
            imemREN1 = 1'b1; imemaddr1 = a; #1;
            chk("dm_miss", 32'(ihit1), 32'd0);
            seen = 0;
            cyc = 0;
            while (cyc < 20) begin
                @(negedge CLK); #1;
                cyc++;
                if (iREN1) seen = 1;
                else if (seen) break;
            end
            chk("dm_fill_done", 32'(seen && cyc < 20), 32'd1);
            chk("dm_hit", 32'(ihit1), 32'd1);
            chk("dm_data", imemload1, memf(a));
            chk("dm_mc", 32'(miss_count1), 32'(k + 1));
            imemREN1 = 1'b0;
            @(negedge CLK); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
